// File: rtl/puf_resp_uart_tx.sv
// ---------------------------------------------------------------------------
// puf_resp_uart_tx
//   Sends one 32-bit PUF response word as four 8N1 UART frames. The frames go
//   back to back, with byte 0 (data[7:0]) first and LSB first inside each byte.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   transmit request, sampled on the rising edge
//   data   in   32-bit word to send, latched when start is accepted
//   tx     out  UART line (idle high), driven straight from a flop
//   busy   out  high while a word is being sent
//   done   out  one-cycle pulse at the end of the 4th stop bit
// ---------------------------------------------------------------------------
module puf_resp_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  state_q, state_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shreg_q, shreg_d;

  logic        bit_end;
  logic        accept;

  // The baud counter runs from 0 to CLKS_PER_BIT-1 in every bit. The edge
  // where it reads CLKS_PER_BIT-1 is the bit boundary.
  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = 16'd0;
        accept = start;
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end

      // The shift register gives up one bit per data bit. tx always shows
      // shreg[0], so at a boundary the next bit is shreg[1] before the shift.
      // 32 shifts use up the whole word, one byte after another.
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[31:1]};
          bit_d   = bit_q + 3'd1;
          tx_d    = shreg_q[1];
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (byte_q == 2'd3) begin
            // End of the word. done fires here. If start is high on this
            // same edge, the next word's start bit begins at once, so a word
            // held on start never leaves an idle bit on the line.
            done_d  = 1'b1;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
            accept  = start;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_START;
      shreg_d = data;
      byte_d  = 2'd0;
      bit_d   = 3'd0;
      baud_d  = 16'd0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      shreg_q <= 32'd0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/puf_resp_uart_tx.md
PUF_RESP_UART_TX -- requirements
Module: puf_resp_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to transmit data; sampled on rising clk edge.
REQ-005 data  input  32  PUF response word to transmit.
REQ-006 tx  output  1  UART serial line, idle high.
REQ-007 busy  output  1  high while a 4-byte transmission is in progress.
REQ-008 done  output  1  one-cycle pulse marking the end of the 4th stop bit.

Function
REQ-009 The block SHALL serialize one 32-bit word as 4 UART frames, 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1.
REQ-010 Byte order SHALL be data[7:0], data[15:8], data[23:16], data[31:24].
REQ-011 Frames SHALL be back-to-back, with no idle gap between one stop bit and the next start bit.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and no others.
REQ-013 In IDLE, start=1 at edge k SHALL:
- latch data into an internal shift register;
- clear the byte counter (0..3);
- set state to START and drive tx=0 and busy=1, all from edge k.
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-015 State transitions:
- START -> DATA after 1 bit time.
- DATA -> STOP after the 8th bit; a 3-bit bit counter counts 0..7.
- STOP -> START when the byte counter is below 3; the byte counter increments.
- STOP -> IDLE when the byte counter equals 3.
REQ-016 A full transfer SHALL take exactly 40*CLKS_PER_BIT cycles: tx falls at edge k, and the IDLE return occurs at edge k+40*CLKS_PER_BIT.
REQ-017 At the IDLE return edge, done SHALL go high for exactly one cycle, busy SHALL go low, and tx SHALL be 1.
REQ-018 start SHALL be ignored while busy=1; the latched word SHALL NOT change while busy=1, even if data changes.
REQ-019 start sampled in the cycle done=1 (state already IDLE) SHALL be accepted, giving back-to-back words with no idle bit.
REQ-020 start held high continuously SHALL produce continuous back-to-back words; each word SHALL use the data value present at its accept edge.
REQ-021 tx SHALL be driven directly from a flip-flop, glitch-free.
REQ-022 Outside a transfer, tx SHALL be 1 and done SHALL be 0.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force:
- state IDLE, tx=1, busy=0, done=0;
- baud, bit and byte counters to 0;
- shift register to 0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer; the partial frame SHALL NOT resume, and no done pulse SHALL be issued.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification (bench uses CLKS_PER_BIT=4)
REQ-026 Single word: data=32'hA5C3_0F81, start pulse at edge k.
- tx sequence SHALL be 0,10000001,1, 0,11110000,1, 0,11000011,1, 0,10100101,1, with data bits listed in transmit order, each bit 4 cycles;
- done SHALL pulse at edge k+160 and busy SHALL be high from k to k+159.
REQ-027 Ignored start: a second start with data=32'hFFFF_FFFF at edge k+50 SHALL leave the tx waveform identical to REQ-026 and produce exactly one done pulse.
REQ-028 Back-to-back: start held high with data=32'h0000_0000, then 32'h1234_5678 presented at edge k+160.
- The second word's start bit SHALL begin at edge k+160 with no idle bit.
- The decoded bytes SHALL be 00,00,00,00,78,56,34,12.
REQ-029 Reset mid-transfer: rst_n=0 at edge k+70, asynchronous, mid-cycle.
- tx=1 and busy=0 SHALL hold before the next clk edge.
- No done pulse SHALL occur.
- A new start after release SHALL transmit correctly.
REQ-030 Loopback: feed tx into the existing 32-bit receive model and compare against 1000 random words; all SHALL match, with exactly 1000 done pulses.
